// File: rtl/cpu2021_pkg.sv
// ----------------------------------------------------------------------------
// cpu2021_pkg
// Shared definitions for the RAM port arbiter slice.
//   AW, DW      : default RAM address / data widths (8K x 16 macro)
//   PRIO_FIXED  : arbitration mode, port 0 always wins a contest
//   PRIO_RR     : arbitration mode, the port not granted last wins a contest
//   arb_state_t : arbiter FSM states (open contest / locked to port 0 / port 1)
// ----------------------------------------------------------------------------
package cpu2021_pkg;

  localparam int AW = 13;
  localparam int DW = 16;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter_if
// One requester port of the RAM arbiter.
//   req / we / addr / wdata / lock : request side, driven by the requester
//   gnt    : access accepted this cycle when req & gnt (combinational)
//   rvalid : read data for this port's accepted read is on rdata
//   rdata  : RAM read data, qualified by rvalid
// Modports: master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface ram_port_arbiter_if
  #(parameter int AW = cpu2021_pkg::AW,
    parameter int DW = cpu2021_pkg::DW);

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          lock;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, lock,
                  input  gnt, rvalid, rdata);

  modport slave  (input  req, we, addr, wdata, lock,
                  output gnt, rvalid, rdata);

endinterface

// File: rtl/arb_pick2.sv
// ----------------------------------------------------------------------------
// arb_pick2
// Combinational winner selection between two eligible requests.
//   MODE : PRIO_FIXED (port 0 wins ties) or PRIO_RR (port != last wins ties)
//   req  : eligible requests, bit N = port N
//   last : index of the port granted most recently
//   gnt  : one-hot (or zero) grant, never set without the matching req bit
// ----------------------------------------------------------------------------
module arb_pick2
  import cpu2021_pkg::*;
  #(parameter int MODE = PRIO_RR)
  (input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt);

  always_comb begin
    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    gnt = req;
    if (req == 2'b11) begin
      if (MODE == PRIO_FIXED) begin
        gnt = 2'b01;
      end else begin
        gnt = last ? 2'b01 : 2'b10;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter
// Shares the single-port program/data RAM between the CPU core (port 0) and
// the host loader / debug port (port 1). One access per cycle, read data
// returned to the issuing port one cycle later, optional lock to keep
// ownership across a sequence of accesses.
//   clk, rst   : clock, synchronous active-high reset
//   m0, m1     : requester ports (ram_port_arbiter_if.slave)
//   ram_addr   : RAM address, 0 when nothing is granted
//   ram_wdata  : RAM write data, 0 unless a write is granted
//   ram_wrEn   : RAM write enable, granted port's we
//   ram_rdata  : RAM read data, valid one cycle after a read address
// ----------------------------------------------------------------------------
module ram_port_arbiter
  import cpu2021_pkg::*;
  #(parameter int AW        = cpu2021_pkg::AW,
    parameter int DW        = cpu2021_pkg::DW,
    parameter int PRIO_MODE = PRIO_RR)
  (input  logic                 clk,
   input  logic                 rst,
   ram_port_arbiter_if.slave    m0,
   ram_port_arbiter_if.slave    m1,
   output logic [AW-1:0]        ram_addr,
   output logic [DW-1:0]        ram_wdata,
   output logic                 ram_wrEn,
   input  logic [DW-1:0]        ram_rdata);

  arb_state_t state_q, state_d;
  logic       last_q;
  logic       rd_pend_q;
  logic       rd_owner_q;

  logic [1:0] elig;
  logic [1:0] pick;
  logic [1:0] gnt;
  logic       sel_we;

  // A locked owner masks the other port out of the contest entirely.
  always_comb begin
    elig = 2'b00;
    unique case (state_q)
      IDLE:    elig = {m1.req, m0.req};
      OWN0:    elig = {1'b0,   m0.req};
      OWN1:    elig = {m1.req, 1'b0};
      default: elig = 2'b00;
    endcase
  end

  arb_pick2 #(.MODE(PRIO_MODE)) u_pick (
    .req  (elig),
    .last (last_q),
    .gnt  (pick)
  );

  // Grants are suppressed while reset is held so the RAM sees no access.
  always_comb begin
    gnt     = rst ? 2'b00 : pick;
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (gnt[0] && m0.lock)      state_d = OWN0;
        else if (gnt[1] && m1.lock) state_d = OWN1;
      end
      // In OWNn the owner is always granted when it requests, so leaving
      // covers both an unlocked access and a dropped request.
      OWN0:    state_d = (gnt[0] && m0.lock) ? OWN0 : IDLE;
      OWN1:    state_d = (gnt[1] && m1.lock) ? OWN1 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (|gnt) last_q <= gnt[1];
      rd_pend_q  <= (|gnt) && !sel_we;
      rd_owner_q <= gnt[1];
    end
  end

  // RAM mux: at most one grant bit is set, so gnt[1] selects the port.
  always_comb begin
    sel_we    = gnt[1] ? m1.we : m0.we;
    ram_wrEn  = (|gnt) && sel_we;
    ram_addr  = '0;
    ram_wdata = '0;
    if (|gnt) ram_addr = gnt[1] ? m1.addr : m0.addr;
    if (ram_wrEn) ram_wdata = gnt[1] ? m1.wdata : m0.wdata;
  end

  assign m0.gnt    = gnt[0];
  assign m1.gnt    = gnt[1];
  assign m0.rvalid = rd_pend_q && !rd_owner_q;
  assign m1.rvalid = rd_pend_q &&  rd_owner_q;
  assign m0.rdata  = ram_rdata;
  assign m1.rdata  = ram_rdata;

endmodule
